// File: rtl/arb_pkg.sv
// Shared types, sizes and the rotating-priority select for the round-robin arbiter.
package arb_pkg;

    localparam int unsigned ARB_N     = 8;
    localparam int unsigned ARB_IDX_W = 3;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // First set request bit scanning upward from ptr, wrapping 7->0; returns ptr when req is zero.
    function automatic logic [ARB_IDX_W-1:0] rr_pick(
        input logic [ARB_N-1:0]     req,
        input logic [ARB_IDX_W-1:0] ptr
    );
        logic [ARB_IDX_W-1:0] pick;
        logic [ARB_IDX_W-1:0] idx;
        logic                 found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < ARB_N; i++) begin
            idx = ptr + ARB_IDX_W'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/decoder_3to8.sv
// 3-to-8 one-hot decoder.
module decoder_3to8 (
    input  logic [2:0] a,
    output logic [7:0] y
);

    // Exactly one output bit set, selected by a.
    always_comb begin
        y    = 8'h00;
        y[a] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with optional grant hold limit.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ARB_N-1:0]     req,
    output logic [ARB_N-1:0]     gnt,
    output logic [ARB_IDX_W-1:0] gnt_idx,
    output logic                 gnt_valid,
    output logic                 expired
);

    localparam int unsigned CNT_W = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

    arb_state_e           state, state_nx;
    logic [ARB_IDX_W-1:0] ptr, ptr_nx;
    logic [ARB_IDX_W-1:0] idx_nx;
    logic                 valid_nx;
    logic                 expired_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic [ARB_N-1:0]     dec_y;

    // State, pointer, hold counter and registered outputs; synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            ptr       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            expired   <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            gnt_idx   <= idx_nx;
            gnt_valid <= valid_nx;
            expired   <= expired_nx;
            cnt       <= cnt_nx;
        end
    end

    // Arbitration, release/expiry decisions and hold counting.
    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        idx_nx     = gnt_idx;
        valid_nx   = gnt_valid;
        expired_nx = 1'b0;
        cnt_nx     = cnt;
        unique case (state)
            ARB_IDLE: begin
                if (req != '0) begin
                    idx_nx   = rr_pick(req, ptr);
                    valid_nx = 1'b1;
                    cnt_nx   = '0;
                    state_nx = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (!req[gnt_idx]) begin
                    valid_nx = 1'b0;
                    ptr_nx   = gnt_idx + ARB_IDX_W'(1);
                    state_nx = ARB_IDLE;
                end else if ((HOLD_MAX != 0) && (cnt == CNT_LAST)) begin
                    valid_nx   = 1'b0;
                    ptr_nx     = gnt_idx + ARB_IDX_W'(1);
                    expired_nx = 1'b1;
                    state_nx   = ARB_IDLE;
                end else if (cnt != CNT_SAT) begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: state_nx = ARB_IDLE;
        endcase
    end

    decoder_3to8 u_dec (
        .a (gnt_idx),
        .y (dec_y)
    );

    assign gnt = dec_y & {ARB_N{gnt_valid}};

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: two instances (hold limit 16 and 3) against a behavioural model.
module tb_rr_arbiter_8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;

    logic [7:0] gnt_a, gnt_b;
    logic [2:0] idx_a, idx_b;
    logic       vld_a, vld_b;
    logic       exp_a, exp_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rr_arbiter_8 u_a (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(vld_a), .expired(exp_a)
    );

    rr_arbiter_8 #(.HOLD_MAX(3)) u_b (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(vld_b), .expired(exp_b)
    );

    // Model: per instance, who owns the slot, how many granted cycles it has had, next priority.
    int  m_hold [2] = '{16, 3};
    bit  m_busy [2];
    int  m_owner[2];
    int  m_prio [2];
    int  m_used [2];
    bit  m_exp  [2];
    bit  started = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_busy[k] = 0; m_owner[k] = 0; m_prio[k] = 0; m_used[k] = 0; m_exp[k] = 0;
            end else if (!m_busy[k]) begin
                m_exp[k] = 0;
                if (req != 8'h00) begin
                    bit found;
                    found = 0;
                    for (int s = 0; s < 8; s++) begin
                        int c;
                        c = (m_prio[k] + s) % 8;
                        if (!found && req[c]) begin
                            m_owner[k] = c;
                            found = 1;
                        end
                    end
                    m_busy[k] = 1;
                    m_used[k] = 1;
                end
            end else if (!req[m_owner[k]]) begin
                m_busy[k] = 0; m_prio[k] = (m_owner[k] + 1) % 8; m_exp[k] = 0;
            end else if (m_hold[k] != 0 && m_used[k] == m_hold[k]) begin
                m_busy[k] = 0; m_prio[k] = (m_owner[k] + 1) % 8; m_exp[k] = 1;
            end else begin
                m_used[k] = m_used[k] + 1;
                m_exp[k]  = 0;
            end
        end
        started = 1'b1;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                logic [7:0] e_gnt;
                e_gnt = m_busy[k] ? (8'h01 << m_owner[k]) : 8'h00;
                chk(k ? "model_gnt_b" : "model_gnt_a", k ? gnt_b : gnt_a, e_gnt);
                chk(k ? "model_idx_b" : "model_idx_a", 8'(k ? idx_b : idx_a), 8'(m_owner[k]));
                chk(k ? "model_vld_b" : "model_vld_a", 8'(k ? vld_b : vld_a), 8'(m_busy[k]));
                chk(k ? "model_exp_b" : "model_exp_a", 8'(k ? exp_b : exp_a), 8'(m_exp[k]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with all requests high.
        rst_n = 1'b0;
        req   = 8'hFF;
        tick(); tick();
        chk("rst_gnt_a", gnt_a, 8'h00);
        chk("rst_vld_a", 8'(vld_a), 8'h00);
        chk("rst_idx_a", 8'(idx_a), 8'h00);
        chk("rst_exp_a", 8'(exp_a), 8'h00);
        chk("rst_gnt_b", gnt_b, 8'h00);

        // Single requester 4, held for cycles 1..4.
        rst_n = 1'b1;
        req   = 8'h00;
        tick();
        req = 8'h10;
        tick();
        for (int c = 1; c <= 4; c++) begin
            chk("single_gnt", gnt_a, 8'h10);
            chk("single_idx", 8'(idx_a), 8'h04);
            if (c == 4) req = 8'h00;
            tick();
        end
        chk("single_release", gnt_a, 8'h00);

        // Round robin with hold limit 3 on instance b, pointer starting at 0.
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        req   = 8'hFF;
        tick();
        for (int g = 0; g < 9; g++) begin
            for (int c = 0; c < 3; c++) begin
                chk("rr_gnt", gnt_b, 8'h01 << (g % 8));
                chk("rr_idx", 8'(idx_b), 8'(g % 8));
                chk("rr_noexp", 8'(exp_b), 8'h00);
                tick();
            end
            chk("rr_idle", gnt_b, 8'h00);
            chk("rr_exp", 8'(exp_b), 8'h01);
            tick();
        end

        // Wrap and skip: grant 5 then release leaves pointer at 6.
        req = 8'h00;
        tick(); tick();
        req = 8'h20;
        tick();
        chk("wrap_g5", gnt_a, 8'h20);
        req = 8'h00;
        tick();
        req = 8'h05;
        tick();
        chk("wrap_g0", gnt_a, 8'h01);
        chk("wrap_i0", 8'(idx_a), 8'h00);
        req = 8'h04;
        tick();
        chk("wrap_gap", gnt_a, 8'h00);
        tick();
        chk("wrap_g2", gnt_a, 8'h04);
        chk("wrap_i2", 8'(idx_a), 8'h02);

        // No preemption: requester 1 arrives while 3 holds.
        req = 8'h00;
        tick(); tick();
        req = 8'h08;
        tick();
        chk("nopre_g3", gnt_a, 8'h08);
        req = 8'h0A;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("nopre_hold", gnt_a, 8'h08);
        end
        req = 8'h02;
        tick();
        chk("nopre_gap", gnt_a, 8'h00);
        tick();
        chk("nopre_g1", gnt_a, 8'h02);
        chk("nopre_i1", 8'(idx_a), 8'h01);

        // Reset in the middle of a grant on 5.
        req = 8'h00;
        tick(); tick();
        req = 8'h20;
        tick();
        chk("mrst_g5", gnt_a, 8'h20);
        chk("mrst_i5", 8'(idx_a), 8'h05);
        tick();
        rst_n = 1'b0;
        tick();
        chk("mrst_gnt", gnt_a, 8'h00);
        chk("mrst_idx", 8'(idx_a), 8'h00);
        chk("mrst_vld", 8'(vld_a), 8'h00);
        rst_n = 1'b1;
        req   = 8'h21;
        tick();
        chk("mrst_g0", gnt_a, 8'h01);
        chk("mrst_i0", 8'(idx_a), 8'h00);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
